// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60Hz VGA timing generator (pixel enable, h/v counters, syncs)
//
// Ports:
//   clk        system clock (100 MHz nominal)
//   rst        asynchronous active-low reset (0 = reset)
//   hsync      horizontal sync, active-low, registered
//   vsync      vertical sync, active-low, registered
//   video_on   high while (pixel_x, pixel_y) is inside the visible area
//   p_tick     one-clk pixel enable, once every CLK_DIV clocks
//   pixel_x    current horizontal count, 0..H_TOTAL-1
//   pixel_y    current vertical count, 0..V_TOTAL-1
//   frame_tick (only when VGA_FRAME_TICK_EN is defined) one-clk pulse on the
//              pixel tick that leaves the last visible pixel of the frame
//
// Optional feature macro: VGA_FRAME_TICK_EN
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
`ifdef VGA_FRAME_TICK_EN
    output logic [9:0] pixel_y,
    output logic       frame_tick
`else
    output logic [9:0] pixel_y
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       div_last;

    assign div_last = (div_cnt == DIV_MAX);

    // Next-state counters. The vertical counter only moves on the pixel tick
    // where the horizontal counter wraps, so (H_MAX,V_MAX) -> (0,0) is one step.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_cnt == H_MAX) begin
                h_next = '0;
                if (v_cnt == V_MAX) begin
                    v_next = '0;
                end else begin
                    v_next = v_cnt + 10'd1;
                end
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counts so the registered syncs change
    // on the same edge as pixel_x/pixel_y, with no pipeline skew.
    always_comb begin
        hsync_next = !((h_next >= HS_START) && (h_next <= HS_END));
        vsync_next = !((v_next >= VS_START) && (v_next <= VS_END));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            div_cnt <= div_last ? 4'd0 : div_cnt + 4'd1;
            p_tick  <= div_last;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync   <= hsync_next;
            vsync   <= vsync_next;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Registered alongside p_tick: the counters are stable during the div_last
    // cycle (p_tick is low then), so this fires together with the p_tick that
    // moves the position off the last visible pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= div_last && (h_cnt == H_VIS - 10'd1) && (v_cnt == V_VIS - 10'd1);
        end
    end
`endif

    assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;

endmodule
